// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//   Request-side controller for a single-port synchronous SRAM with an
//   active-low write enable and one-cycle registered read data. It turns
//   valid/ready burst requests into per-beat SRAM cycles with address
//   auto-increment. Write beats come from the wdata stream. Read beats come
//   back on a backpressured response stream that is buffered in a small FIFO.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_*               burst request (write flag, start address, beats-1)
//   wdata_*             write beat stream (accepted only in WRITE)
//   rsp_*               read response stream (data + last-beat tag)
//   sram_we_n/addr/din  registered SRAM inputs
//   sram_dout           SRAM registered read data
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  // Burst sequencing
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;

  // SRAM pin registers
  logic                  we_n_q, we_n_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;

  // Two-stage in-flight pipe: stage 1 covers the cycle the SRAM samples the
  // address, and stage 2 covers the cycle its registered data is valid.
  logic                  v1_q, v1_d, l1_q, l1_d;
  logic                  v2_q, v2_d, l2_q, l2_d;

  // Response FIFO, which stores {last, data} per entry
  logic [DATA_WIDTH:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WIDTH:0]   head;

  logic                  req_fire, wr_beat, rd_beat, push, pop;
  logic [OCC_W-1:0]      occ;

  // Read issue is credit-based. Beats already in flight reserve a FIFO slot,
  // so a push can never find the FIFO full.
  assign occ      = OCC_W'(fifo_cnt_q) + OCC_W'(v1_q) + OCC_W'(v2_q);
  assign req_fire = req_valid && req_ready;
  assign wr_beat  = (state_q == WRITE) && wdata_valid;
  assign rd_beat  = (state_q == READ) && (occ < OCC_W'(RSP_DEPTH));
  assign push     = v2_q;
  assign pop      = rsp_valid && rsp_ready;

  // req_ready is gated by rst because the state already reads IDLE while
  // reset is held.
  assign req_ready   = (state_q == IDLE) && !rst;
  assign wdata_ready = (state_q == WRITE);

  assign head      = fifo_mem[rd_ptr_q];
  assign rsp_valid = (fifo_cnt_q != '0);
  // The head is masked while the FIFO is empty because the storage itself is
  // never cleared.
  assign rsp_data  = rsp_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rsp_last  = rsp_valid && head[DATA_WIDTH];

  assign sram_we_n = we_n_q;
  assign sram_addr = sram_addr_q;
  assign sram_din  = din_q;

  always_comb begin
    // NOTE: every signal gets its default first so that no path through this
    // block leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    we_n_d      = 1'b1;
    sram_addr_d = sram_addr_q;
    din_d       = din_q;
    v1_d        = rd_beat;
    l1_d        = rd_beat && last_q;
    v2_d        = v1_q;
    l2_d        = l1_q;
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          addr_d  = req_addr;
          cnt_d   = req_len;
          last_d  = (req_len == '0);
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (wr_beat || rd_beat) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          last_d = (cnt_q == LEN_WIDTH'(1));
          if (last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // During a write bubble only we_n is released. The address and data pins
    // keep their last values.
    if (wr_beat) begin
      we_n_d      = 1'b0;
      sram_addr_d = addr_q;
      din_d       = wdata;
    end else if (rd_beat) begin
      sram_addr_d = addr_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      we_n_q      <= 1'b1;
      sram_addr_q <= '0;
      din_q       <= '0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      v2_q        <= 1'b0;
      l2_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      we_n_q      <= we_n_d;
      sram_addr_q <= sram_addr_d;
      din_q       <= din_d;
      v1_q        <= v1_d;
      l1_q        <= l1_d;
      v2_q        <= v2_d;
      l2_q        <= l2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // NOTE: the FIFO storage has no reset. Flushing is done by clearing the
  // pointers and the count, and the empty-masking above hides stale entries.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {l2_q, sram_dout};
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//   Directed bench for sram_ctrl with a behavioural SRAM model. A reference
//   copy of the memory contents produces the expected read data, and that
//   data is queued when a read request is driven. A monitor compares each
//   response handshake against the head of the queue.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0;
  logic [3:0] req_addr = '0, req_len = '0;
  logic       req_ready;
  logic       wdata_valid = 1'b0;
  logic [7:0] wdata = '0;
  logic       wdata_ready;
  logic       rsp_valid, rsp_last;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       sram_we_n;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout = '0;

  logic [7:0] sram_mem [16];
  logic [7:0] ref_mem  [16];
  exp_t       exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(4), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last),
    .sram_we_n(sram_we_n), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  // Synchronous SRAM: write on we_n low, registered read data
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_din;
    sram_dout <= sram_mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every handshake must match the oldest expected beat
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      exp_t e;
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL rsp_unexpected: observed data %0h with no beat outstanding", rsp_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_last", rsp_last, e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [3:0] a, input logic [3:0] l);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check("req_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [3:0] a, input logic [7:0] d);
    wdata_valid = 1'b1; wdata = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wdata_ready) break;
    end
    check("wdata_ready", wdata_ready, 1);
    tick();
    wdata_valid = 1'b0;
    check("w_we_n", sram_we_n, 0);
    check("w_addr", sram_addr, a);
    check("w_din", sram_din, d);
    ref_mem[a] = d;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] l);
    for (int i = 0; i <= int'(l); i++) begin
      exp_t e;
      logic [3:0] ea;
      ea = a + 4'(i);
      e.last = (i == int'(l));
      e.data = ref_mem[ea];
      exp_q.push_back(e);
    end
    do_req(1'b0, a, l);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
    check("drain_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    logic [3:0] ea;
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end

    // Reset values
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_din", sram_din, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_last", rsp_last, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rel_req_ready", req_ready, 1);

    // Fill the whole SRAM with distinct values
    rsp_ready = 1'b1;
    do_req(1'b1, 4'd0, 4'd15);
    for (int i = 0; i < 16; i++) wbeat(4'(i), 8'hC0 + 8'(i));
    check("wr_done_idle", req_ready, 1);

    // Write A0..A3 at 2, then read back with first-response timing
    do_req(1'b1, 4'd2, 4'd3);
    for (int i = 0; i < 4; i++) wbeat(4'd2 + 4'(i), 8'hA0 + 8'(i));
    rd(4'd2, 4'd3);
    check("t1_rsp_valid_c0", rsp_valid, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t1_rsp_valid_lat", rsp_valid, (c == 3) ? 1 : 0);
    end
    drain();

    // Wrapping write and read from address 14
    do_req(1'b1, 4'd14, 4'd3);
    for (int i = 0; i < 4; i++) wbeat(4'd14 + 4'(i), 8'h50 + 8'(i));
    rd(4'd14, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      tick();
      ea = 4'd14 + 4'(c - 1);
      check("t2_addr_seq", sram_addr, ea);
      check("t2_we_n", sram_we_n, 1);
    end
    drain();

    // Write with wdata_valid toggling 1,0,1,0
    do_req(1'b1, 4'd8, 4'd1);
    wdata_valid = 1'b1; wdata = 8'h71;
    tick();
    check("t4_we_n_b0", sram_we_n, 0);
    check("t4_addr_b0", sram_addr, 8);
    check("t4_din_b0", sram_din, 8'h71);
    ref_mem[8] = 8'h71;
    wdata_valid = 1'b0; wdata = 8'hEE;
    tick();
    check("t4_we_n_bubble", sram_we_n, 1);
    check("t4_addr_bubble", sram_addr, 8);
    check("t4_din_bubble", sram_din, 8'h71);
    wdata_valid = 1'b1; wdata = 8'h72;
    tick();
    check("t4_we_n_b1", sram_we_n, 0);
    check("t4_addr_b1", sram_addr, 9);
    check("t4_din_b1", sram_din, 8'h72);
    ref_mem[9] = 8'h72;
    wdata_valid = 1'b0;
    check("t4_wdata_ready_off", wdata_ready, 0);
    tick();
    check("t4_we_n_end", sram_we_n, 1);
    rd(4'd8, 4'd1);
    drain();

    // Full-depth read under backpressure: issue stalls after 4 beats
    rsp_ready = 1'b0;
    rd(4'd0, 4'd15);
    for (int c = 1; c <= 10; c++) begin
      tick();
      ea = (c < 4) ? 4'(c - 1) : 4'd3;
      check("t3_addr_stall", sram_addr, ea);
    end
    check("t3_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    drain();

    // Reset mid-read with beats in flight and FIFO non-empty
    rsp_ready = 1'b0;
    rd(4'd0, 4'd7);
    tick(); tick(); tick();
    check("t5_pre_rsp_valid", rsp_valid, 1);
    rst = 1'b1;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_we_n", sram_we_n, 1);
    check("t5_addr", sram_addr, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_req_ready", req_ready, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("t5_rel_req_ready", req_ready, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_no_stale", rsp_valid, 0);
    end

    // Write 0x5A to 7 immediately followed by a read of 7
    do_req(1'b1, 4'd7, 4'd0);
    wbeat(4'd7, 8'h5A);
    check("t6_idle_after_write", req_ready, 1);
    rd(4'd7, 4'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Request-side controller for the single-port synchronous SRAM macro (active-low write enable, one-cycle registered read data). Converts valid/ready burst requests from the upstream agent into per-beat SRAM cycles, with address auto-increment, a write-data stream and a backpressured read-response stream. It sits directly in front of the SRAM, and owns every SRAM input and the capture of the SRAM's read data.

## Interface
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 4, SRAM address width (depth 2**ADDR_WIDTH)
- LEN_WIDTH, 4, burst length field width; beats = req_len + 1
- RSP_DEPTH, 4, read response FIFO depth (power of 2, ≥ 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid & ready
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_WIDTH  start address
- req_len  in  LEN_WIDTH  beats minus one
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  write beat accepted
- wdata  in  DATA_WIDTH  write beat data
- rsp_valid  out  1  read beat available
- rsp_ready  in  1  downstream accepts read beat
- rsp_data  out  DATA_WIDTH  read beat data
- rsp_last  out  1  final beat of a read burst
- sram_we_n  out  1  SRAM write enable, active low, registered
- sram_addr  out  ADDR_WIDTH  SRAM address, registered
- sram_din  out  DATA_WIDTH  SRAM write data, registered
- sram_dout  in  DATA_WIDTH  SRAM registered read data

## Operation
- FSM states: IDLE, WRITE, READ.
- IDLE: req_ready=1. On handshake, latch addr, beat counter = req_len and last flag; go to WRITE or READ. All other states: req_ready=0.
- WRITE: wdata_ready=1. Each wdata handshake loads sram_we_n=0, sram_addr=current addr, sram_din=wdata. No wdata that cycle → sram_we_n=1 (bubble), addr/din hold. After the beat with counter 0 → IDLE.
- READ: issue one beat per cycle when (fifo_count + inflight) < RSP_DEPTH. Issuing loads sram_addr=current addr with sram_we_n=1; otherwise stall, sram_addr holds. After the beat with counter 0 → IDLE. Outstanding beats drain while the FSM is in IDLE or a later burst.
- Address increments by 1 per issued beat, modulo 2**ADDR_WIDTH (wraps 2**ADDR_WIDTH-1 → 0).
- Each read beat carries a last tag through a 2-stage in-flight pipe. The tag is pushed with the data into the response FIFO and appears as rsp_last.
- Response FIFO: rsp_valid = FIFO not empty; rsp_data and rsp_last come from the head entry. Pop on rsp_valid & rsp_ready. Push and pop may happen in the same cycle.
- Ordering is strictly issue order. A read issued after a write to the same address returns the new data. Write and read beats never overlap in the same cycle.
- Reset (async, any time): state=IDLE, counters and inflight cleared, FIFO flushed, in-flight beats discarded. Outputs: sram_we_n=1, sram_addr=0, sram_din=0, rsp_valid=0, rsp_data=0, rsp_last=0, wdata_ready=0, req_ready=0 while rst is high, and 1 from the first cycle after release.

## Timing
- Request accept at edge E0. The first beat can be registered onto SRAM pins at E1.
- Write: beat registered at edge Ek; SRAM commits the write at Ek+1.
- Read: address registered at Ek; SRAM samples it at Ek+1; sram_dout is captured into the FIFO at Ek+2; rsp_valid is high in the cycle after Ek+2 when the FIFO was empty. Load-to-rsp_valid is 2 cycles.
- Back-to-back reads with rsp_ready=1 sustain one beat per cycle.
- inflight ≤ 2. With rsp_ready=0, at most RSP_DEPTH beats are issued before the issue stall.
- A new request is accepted in the cycle after the previous burst's last beat is issued (one IDLE cycle).

## Test plan
- Write 4 beats from addr 2 with data 0xA0..0xA3, then read 4 beats from addr 2 -> rsp_data 0xA0,0xA1,0xA2,0xA3 with rsp_last only on 0xA3; first rsp_valid 3 cycles after the read request is accepted.
- Read len=3 from addr 14 (ADDR_WIDTH=4) -> sram_addr sequence 14,15,0,1; returned data matches prior writes at those addresses.
- Read len=15 with rsp_ready=0 -> issue stalls after exactly 4 beats, and sram_addr holds. Raising rsp_ready then delivers all 16 beats in order, with no loss or duplication.
- Write burst with wdata_valid toggling 1,0,1,0 -> sram_we_n low only in the cycles following accepted beats; the address advances only on accepted beats.
- Assert rst mid-read with 2 beats in flight and FIFO non-empty -> immediately rsp_valid=0, sram_we_n=1, sram_addr=0. After release, req_ready=1 and stale data is never returned.
- Write 0x5A to addr 7 immediately followed by a read of addr 7 -> rsp_data=0x5A.
